// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter: FSM state encoding and the
// line levels used for idle/stop and start bits.
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state).
// -----------------------------------------------------------------------------
package uart_pkg;

  // Encodings are fixed so a debug probe reads the same value in both builds;
  // PARITY simply does not exist when parity is compiled out.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_START = 3'd1,
    START      = 3'd2,
    DATA       = 3'd3,
`ifdef UART_TX_PARITY_EN
    PARITY     = 3'd4,
`endif
    STOP       = 3'd5
  } uart_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;  // line level when idle and for stop bits
  localparam logic START_LEVEL = 1'b0;  // line level of the start bit

endpackage

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// Serialises one DATA_W-bit word per frame onto a UART line. Bit timing comes
// entirely from the external 'tick' strobe (one pulse per bit period).
// Frame: start bit, DATA_W data bits LSB first, optional even parity bit,
// STOP_BITS stop bits.
//
// Optional feature macro: UART_TX_PARITY_EN -- when defined, one even-parity
// bit (XOR of the data bits) is sent after the last data bit.
//
// Parameters:
//   DATA_W    data bits per frame, 5..8
//   STOP_BITS stop bits per frame, 1 or 2
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   tick       in   bit-period strobe, one clk cycle wide
//   tx_data    in   word to send, sampled only on acceptance
//   tx_valid   in   requester has a word on tx_data
//   tx_ready   out  block can accept a frame
//   tx         out  serial line, idle high
//   busy       out  frame in progress (always ~tx_ready)
//   dbg_state  out  current FSM state, for observation only
//
// Handshake: a word is accepted on a rising clk edge where tx_valid and
// tx_ready are both high. tx_ready is registered, drops the cycle after
// acceptance and stays low until the frame is finished; tx_valid seen while
// tx_ready is low has no effect. The requester may hold tx_valid high to
// stream frames back to back.
// -----------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy,
  output uart_state_t       dbg_state
);

  // Bit counter only ever needs to reach DATA_W-1.
  localparam int               CNT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_t       r_state;
  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic              r_stop_cnt;
  logic              r_tx;
  logic              r_ready;
`ifdef UART_TX_PARITY_EN
  logic              r_parity;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_tx       <= IDLE_LEVEL;
      r_ready    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      case (r_state)
        // A tick on the acceptance edge is deliberately ignored: the frame
        // waits in WAIT_START for the first tick strictly afterwards.
        IDLE: begin
          if (tx_valid && r_ready) begin
            r_shift <= tx_data;
            r_ready <= 1'b0;
            r_state <= WAIT_START;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^tx_data;
`endif
          end
        end

        WAIT_START: begin
          if (tick) begin
            r_tx    <= START_LEVEL;
            r_state <= START;
          end
        end

        START: begin
          if (tick) begin
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= '0;
            r_state   <= DATA;
          end
        end

        // r_bit_cnt is the index of the bit currently on the line.
        DATA: begin
          if (tick) begin
            if (r_bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              r_tx    <= r_parity;
              r_state <= PARITY;
`else
              r_tx       <= IDLE_LEVEL;
              r_stop_cnt <= 1'b0;
              r_state    <= STOP;
`endif
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            r_tx       <= IDLE_LEVEL;
            r_stop_cnt <= 1'b0;
            r_state    <= STOP;
          end
        end
`endif

        // Line is already high; the tick that ends the last stop bit frees
        // the block, so tx_ready is high on the following cycle.
        STOP: begin
          if (tick) begin
            if (r_stop_cnt == LAST_STOP) begin
              r_state <= IDLE;
              r_ready <= 1'b1;
            end else begin
              r_stop_cnt <= r_stop_cnt + 1'b1;
            end
          end
        end

        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_tx    <= IDLE_LEVEL;
        end
      endcase
    end
  end

  assign tx        = r_tx;
  assign tx_ready  = r_ready;
  assign busy      = ~r_ready;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Two DUTs share clock, reset and tick: dut_a (DATA_W=8, STOP_BITS=1) and
// dut_b (DATA_W=8, STOP_BITS=2). A queue-of-line-levels model per DUT predicts
// tx/tx_ready/busy every cycle; directed tests add literal frame checks.
// Build with +define+UART_TX_PARITY_EN to exercise the parity variant.
// -----------------------------------------------------------------------------
module tb_uart_tx;
  import uart_pkg::*;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic       tick;
  logic       tick_auto  = 1'b0;
  logic       tick_force = 1'b0;
  int         tick_period = 0;
  int         tcnt = 0;
  logic       tx_valid_a, tx_valid_b;
  logic [7:0] tx_data_a, tx_data_b;

  logic        tx_a, rdy_a, busy_a;
  logic        tx_b, rdy_b, busy_b;
  uart_state_t st_a, st_b;

  assign tick = tick_auto | tick_force;

  // Free-running tick: one pulse every tick_period cycles (0 = off).
  always @(negedge clk) begin
    if (tick_period == 0) begin
      tcnt      = 0;
      tick_auto = 1'b0;
    end else begin
      tick_auto = (tcnt == tick_period - 1);
      tcnt      = (tcnt == tick_period - 1) ? 0 : tcnt + 1;
    end
  end

  uart_tx #(.DATA_W(8), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .tick(tick), .tx_data(tx_data_a),
    .tx_valid(tx_valid_a), .tx_ready(rdy_a), .tx(tx_a), .busy(busy_a),
    .dbg_state(st_a)
  );

  uart_tx #(.DATA_W(8), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .tick(tick), .tx_data(tx_data_b),
    .tx_valid(tx_valid_b), .tx_ready(rdy_b), .tx(tx_b), .busy(busy_b),
    .dbg_state(st_b)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // A frame is a list of line levels; each counted tick puts the next level on
  // the line, and the tick after the list is exhausted frees the transmitter.
  logic exp_q_a[$];
  logic exp_q_b[$];
  logic m_tx_a = 1'b1, m_rdy_a = 1'b1;
  logic m_tx_b = 1'b1, m_rdy_b = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q_a.delete(); m_rdy_a = 1'b1; m_tx_a = 1'b1;
    end else if (!m_rdy_a) begin
      if (tick) begin
        if (exp_q_a.size() == 0) begin m_rdy_a = 1'b1; m_tx_a = 1'b1; end
        else m_tx_a = exp_q_a.pop_front();
      end
    end else if (tx_valid_a) begin
      m_rdy_a = 1'b0;
      exp_q_a.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_q_a.push_back(tx_data_a[i]);
      if (P == 1) exp_q_a.push_back(^tx_data_a);
      exp_q_a.push_back(1'b1);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q_b.delete(); m_rdy_b = 1'b1; m_tx_b = 1'b1;
    end else if (!m_rdy_b) begin
      if (tick) begin
        if (exp_q_b.size() == 0) begin m_rdy_b = 1'b1; m_tx_b = 1'b1; end
        else m_tx_b = exp_q_b.pop_front();
      end
    end else if (tx_valid_b) begin
      m_rdy_b = 1'b0;
      exp_q_b.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_q_b.push_back(tx_data_b[i]);
      if (P == 1) exp_q_b.push_back(^tx_data_b);
      for (int s = 0; s < 2; s++) exp_q_b.push_back(1'b1);
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    chk("cyc_tx_a",   16'(tx_a),   16'(m_tx_a));
    chk("cyc_rdy_a",  16'(rdy_a),  16'(m_rdy_a));
    chk("cyc_busy_a", 16'(busy_a), 16'(!m_rdy_a));
    chk("cyc_tx_b",   16'(tx_b),   16'(m_tx_b));
    chk("cyc_rdy_b",  16'(rdy_b),  16'(m_rdy_b));
    chk("cyc_busy_b", 16'(busy_b), 16'(!m_rdy_b));
  end

  // ---------------- driver tasks ----------------
  function automatic logic rdy_k(input int k);
    return (k != 0) ? rdy_b : rdy_a;
  endfunction

  function automatic logic tx_k(input int k);
    return (k != 0) ? tx_b : tx_a;
  endfunction

  // Raise valid with data and return just after the acceptance edge
  // (valid is left high; caller decides when to drop it).
  task automatic accept(input int k, input logic [7:0] d);
    int w;
    @(negedge clk);
    if (k != 0) begin tx_valid_b = 1'b1; tx_data_b = d; end
    else        begin tx_valid_a = 1'b1; tx_data_a = d; end
    w = 0;
    while (!rdy_k(k) && w < 200) begin @(negedge clk); w++; end
    chk("accept_wait", 16'(rdy_k(k)), 16'd1);
    @(posedge clk); #1;
  endtask

  // Record the line level after each counted tick until tx_ready returns.
  task automatic capture(input int k, output logic [15:0] bits, output int n);
    logic tk;
    bits = '0;
    n    = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      tk = tick;
      #1;
      if (rdy_k(k)) break;
      if (tk) begin
        if (n < 16) bits[n] = tx_k(k);
        n++;
      end
    end
    chk("capture_done", 16'(rdy_k(k)), 16'd1);
  endtask

  task automatic check_frame(input string nm, input logic [15:0] bits, input int n,
                             input logic [15:0] exp_bits, input int exp_n);
    chk({nm, "_bits"}, bits, exp_bits);
    chk({nm, "_ticks"}, 16'(n), 16'(exp_n));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    logic [15:0] bits;
    int          n;
    int          cnt;
    int          g;
    tx_valid_a = 1'b0; tx_valid_b = 1'b0;
    tx_data_a  = 8'h00; tx_data_b  = 8'h00;

    // Reset state, checked before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    chk("rst_tx_a",    16'(tx_a),   16'd1);
    chk("rst_rdy_a",   16'(rdy_a),  16'd1);
    chk("rst_busy_a",  16'(busy_a), 16'd0);
    chk("rst_state_a", 16'(st_a),   16'(IDLE));
    chk("rst_tx_b",    16'(tx_b),   16'd1);
    chk("rst_rdy_b",   16'(rdy_b),  16'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick_period = 4;

    // 0x55, tick every 4 clk.
    accept(0, 8'h55); tx_valid_a = 1'b0;
    capture(0, bits, n);
    if (P == 1) check_frame("f55", bits, n, 16'h04AA, 11);
    else        check_frame("f55", bits, n, 16'h02AA, 10);

    // 0x07: three ones -> parity bit 1 when enabled.
    accept(0, 8'h07); tx_valid_a = 1'b0;
    capture(0, bits, n);
    if (P == 1) check_frame("f07", bits, n, 16'h060E, 11);
    else        check_frame("f07", bits, n, 16'h020E, 10);

    // Back to back: valid held, data changed mid-frame.
    accept(0, 8'hA3);
    tx_data_a = 8'h3C;
    capture(0, bits, n);
    if (P == 1) check_frame("fA3", bits, n, 16'h0546, 11);
    else        check_frame("fA3", bits, n, 16'h0346, 10);
    @(posedge clk); #1;
    chk("b2b_accept_rdy", 16'(rdy_a), 16'd0);
    tx_valid_a = 1'b0;
    capture(0, bits, n);
    if (P == 1) check_frame("f3C", bits, n, 16'h0478, 11);
    else        check_frame("f3C", bits, n, 16'h0278, 10);

    // Tick coincident with acceptance is not counted.
    tick_period = 0;
    repeat (3) @(negedge clk);
    tx_valid_a = 1'b1; tx_data_a = 8'h5A; tick_force = 1'b1;
    @(posedge clk); #1;
    tick_force = 1'b0; tx_valid_a = 1'b0;
    chk("coinc_busy", 16'(busy_a), 16'd1);
    chk("coinc_tx",   16'(tx_a),   16'd1);
    repeat (4) @(negedge clk);
    chk("coinc_wait_tx",    16'(tx_a), 16'd1);
    chk("coinc_wait_state", 16'(st_a), 16'(WAIT_START));
    @(negedge clk); tick_force = 1'b1;
    @(posedge clk); #1;
    tick_force = 1'b0;
    chk("coinc_start", 16'(tx_a), 16'd0);
    tick_period = 4;
    capture(0, bits, n);
    if (P == 1) check_frame("f5A_rest", bits, n, 16'h025A, 10);
    else        check_frame("f5A_rest", bits, n, 16'h015A, 9);

    // Reset during data bit 3 of 0xFF.
    accept(0, 8'hFF); tx_valid_a = 1'b0;
    cnt = 0; g = 0;
    while (cnt < 5 && g < 100) begin
      @(posedge clk);
      if (tick) cnt++;
      g++;
    end
    chk("abort_reach_bit3", 16'(cnt), 16'd5);
    @(negedge clk);
    chk("abort_pre_busy", 16'(busy_a), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_tx",    16'(tx_a),   16'd1);
    chk("abort_rdy",   16'(rdy_a),  16'd1);
    chk("abort_busy",  16'(busy_a), 16'd0);
    chk("abort_state", 16'(st_a),   16'(IDLE));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    accept(0, 8'h81); tx_valid_a = 1'b0;
    capture(0, bits, n);
    if (P == 1) check_frame("f81", bits, n, 16'h0502, 11);
    else        check_frame("f81", bits, n, 16'h0302, 10);

    // Two stop bits, 0x00.
    accept(1, 8'h00); tx_valid_b = 1'b0;
    capture(1, bits, n);
    if (P == 1) check_frame("f00_2stop", bits, n, 16'h0C00, 12);
    else        check_frame("f00_2stop", bits, n, 16'h0600, 11);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter: DATA_W, default 8, number of data bits per frame; legal range 5..8.
REQ-002 Parameter: STOP_BITS, default 1, number of stop bits; legal values 1 or 2.
REQ-003 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: tick  input  1  bit-period strobe from the upstream divider; high for one clk cycle per bit period.
REQ-006 Port: tx_data  input  DATA_W  byte to send; sampled only on acceptance.
REQ-007 Port: tx_valid  input  1  requester has data on tx_data.
REQ-008 Port: tx_ready  output  1  block can accept a frame.
REQ-009 Port: tx  output  1  serial line; idle level high.
REQ-010 Port: busy  output  1  frame in progress; always equal to NOT tx_ready.

Function
REQ-011 The FSM SHALL have states IDLE, WAIT_START, START, DATA, PARITY, STOP.
REQ-012 Acceptance SHALL occur on a rising edge where tx_valid and tx_ready are both high; tx_data is latched and the FSM moves IDLE->WAIT_START.
REQ-013 tx_ready SHALL be low from the cycle after acceptance until the frame completes; tx_valid while not ready is ignored.
REQ-014 A tick coinciding with the acceptance edge SHALL NOT count; the first tick strictly after acceptance moves WAIT_START->START and drives tx low.
REQ-015 Each subsequent tick SHALL advance exactly one bit: START->DATA; DATA shifts out bits LSB first over DATA_W ticks; then PARITY (if compiled in), then STOP.
REQ-016 tx SHALL change only on tick edges during a frame and hold its value between ticks.
REQ-017 STOP SHALL drive tx high for STOP_BITS tick periods; the tick ending the last stop bit returns the FSM to IDLE, and tx_ready is high the following cycle.
REQ-018 Frame length from the first counted tick to the return to IDLE SHALL be 1+DATA_W+P+STOP_BITS ticks, where P = 1 with parity, else 0.
REQ-019 A back-to-back frame SHALL be acceptable in the first cycle tx_ready is high; no extra idle bit is inserted beyond the wait for the next tick.
REQ-020 The bit counter SHALL be sized to hold DATA_W-1 and SHALL NOT wrap within a frame.
REQ-021 If tick never arrives, the block SHALL remain in its current state indefinitely with outputs stable.

Reset
REQ-022 While rst_n is low, regardless of clock: tx=1, tx_ready=1, busy=0, FSM=IDLE, shift register and bit counter cleared.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately, with tx high asynchronously; the first acceptance after release starts a fresh frame.

Configuration
REQ-024 Macro UART_TX_PARITY_EN defined: the PARITY state SHALL be included and drive one even-parity bit (XOR of data bits) after the last data bit.
REQ-025 Macro UART_TX_PARITY_EN undefined: the PARITY state and its logic SHALL be absent, and DATA goes directly to STOP.

Structure
REQ-026 Package uart_pkg SHALL hold the FSM state enum typedef, the IDLE_LEVEL constant (1), and the START_LEVEL constant (0).
REQ-027 There SHALL be no sub-module; tick generation stays in the separate divider instance that drives tick.

Verification
REQ-028 Tick every 4 clk, send 0x55, no parity -> tx sequence 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles; tx_ready returns high after 10 ticks.
REQ-029 Parity enabled, send 0x07 -> bits start 0, data 1,1,1,0,0,0,0,0, parity 1, stop 1; 11 ticks total.
REQ-030 tx_valid held high with 0xA3 then 0x3C -> two frames; the second is accepted on the first tx_ready-high cycle; 0x3C LSB is seen after the next tick.
REQ-031 tick asserted in the same cycle as acceptance -> start bit begins on the next tick, not that one; tx stays high until then.
REQ-032 rst_n pulsed low during bit 3 of 0xFF -> tx=1 and tx_ready=1 immediately; a subsequent send of 0x81 yields a correct full frame.
REQ-033 STOP_BITS=2, send 0x00 -> tx high for 2 tick periods after the data bits; total 11 ticks before tx_ready rises.
